// File: rtl/mips_reg_file.sv
// 32 x 32-bit MIPS register file: two combinational read ports with write-through
// bypass, one clocked write port (Rd or Rt destination), reg0 hardwired to zero.
module mips_reg_file (
  input  logic        clk,
  input  logic        arst,
  input  logic        aload,
  input  logic [31:0] busW,
  input  logic        RegWr,
  input  logic        RegDst,
  input  logic [4:0]  Rs,
  input  logic [4:0]  Rt,
  input  logic [4:0]  Rd,
  output logic [31:0] busA,
  output logic [31:0] busB,
  output logic [31:0] r2,
  output logic [31:0] r3,
  output logic [31:0] r4,
  output logic [31:0] r5,
  output logic [31:0] r6,
  output logic [31:0] r7
);

  // Only entries 1..31 hold state; entry 0 is never stored.
  logic [31:0] r_regs [1:31];

  logic [4:0]  w_waddr;
  logic        w_wr_en;
  logic        w_byp_a;
  logic        w_byp_b;
  logic [31:0] w_stored_a;
  logic [31:0] w_stored_b;

  assign w_waddr = RegDst ? Rd : Rt;
  assign w_wr_en = RegWr && !arst && !aload && (w_waddr != 5'd0);

  // Priority: reset, then index preset, then the write port.
  always_ff @(posedge clk) begin
    for (int i = 1; i < 32; i++) begin
      if (arst) begin
        r_regs[i] <= 32'h0000_0000;
      end else if (aload) begin
        r_regs[i] <= 32'(i);
      end else if (w_wr_en && (w_waddr == 5'(i))) begin
        r_regs[i] <= busW;
      end
    end
  end

  always_comb begin
    w_stored_a = 32'h0000_0000;
    w_stored_b = 32'h0000_0000;
    if (Rs != 5'd0) w_stored_a = r_regs[Rs];
    if (Rt != 5'd0) w_stored_b = r_regs[Rt];
  end

  // w_wr_en already excludes reset/preset cycles and address 0.
  assign w_byp_a = w_wr_en && (w_waddr == Rs);
  assign w_byp_b = w_wr_en && (w_waddr == Rt);

  assign busA = w_byp_a ? busW : w_stored_a;
  assign busB = w_byp_b ? busW : w_stored_b;

  assign r2 = r_regs[2];
  assign r3 = r_regs[3];
  assign r4 = r_regs[4];
  assign r5 = r_regs[5];
  assign r6 = r_regs[6];
  assign r7 = r_regs[7];

endmodule

// File: tb/tb_mips_reg_file.sv
// Self-checking bench for mips_reg_file: directed scenarios followed by random
// traffic against an array model of the 32 registers.
module tb_mips_reg_file;

  logic        clk = 1'b0;
  logic        arst, aload, RegWr, RegDst;
  logic [31:0] busW;
  logic [4:0]  Rs, Rt, Rd;
  logic [31:0] busA, busB, r2, r3, r4, r5, r6, r7;

  logic [31:0] model [32];
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  mips_reg_file dut (
    .clk(clk), .arst(arst), .aload(aload), .busW(busW),
    .RegWr(RegWr), .RegDst(RegDst), .Rs(Rs), .Rt(Rt), .Rd(Rd),
    .busA(busA), .busB(busB),
    .r2(r2), .r3(r3), .r4(r4), .r5(r5), .r6(r6), .r7(r7)
  );

  // Expected read value from the architectural rules, including same-cycle bypass.
  function automatic logic [31:0] exp_read(input logic [4:0] a);
    logic [4:0] wa;
    wa = RegDst ? Rd : Rt;
    if (a == 5'd0) return 32'h0;
    if (RegWr && !arst && !aload && wa != 5'd0 && wa == a) return busW;
    return model[a];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/busA"}, busA, exp_read(Rs));
    chk({tag, "/busB"}, busB, exp_read(Rt));
    chk({tag, "/r2"}, r2, model[2]);
    chk({tag, "/r3"}, r3, model[3]);
    chk({tag, "/r4"}, r4, model[4]);
    chk({tag, "/r5"}, r5, model[5]);
    chk({tag, "/r6"}, r6, model[6]);
    chk({tag, "/r7"}, r7, model[7]);
  endtask

  // One rising edge; the model advances from the inputs held across that edge.
  task automatic tick();
    logic [4:0] wa;
    @(posedge clk);
    wa = RegDst ? Rd : Rt;
    if (arst) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (aload) begin
      for (int i = 0; i < 32; i++) model[i] = 32'(i);
      model[0] = 32'h0;
    end else if (RegWr && wa != 5'd0) begin
      model[wa] = busW;
    end
    #1;
  endtask

  task automatic drive(input logic a_rst, input logic a_ld, input logic wr, input logic dst,
                       input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                       input logic [31:0] w);
    arst = a_rst; aload = a_ld; RegWr = wr; RegDst = dst;
    Rs = s; Rt = t; Rd = d; busW = w;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'h0;

    // 1. Reset
    drive(1, 0, 0, 0, 0, 0, 0, 32'h0);
    tick();
    drive(0, 0, 0, 0, 5'd3, 5'd7, 0, 32'h0);
    chk("rst/busA", busA, 32'h0);
    chk("rst/busB", busB, 32'h0);
    check_all("rst");

    // 2. Rd write with bypass on busB
    drive(0, 0, 1, 1, 5'd0, 5'd3, 5'd3, 32'h1);
    chk("rd_wr/busB_bypass", busB, 32'h1);
    chk("rd_wr/busA_zero", busA, 32'h0);
    tick();
    drive(0, 0, 0, 1, 5'd0, 5'd3, 5'd3, 32'h0);
    chk("rd_wr/r3", r3, 32'h1);
    chk("rd_wr/busB_stored", busB, 32'h1);

    // 3. Rt write; r6 untouched
    drive(0, 0, 1, 0, 5'd1, 5'd5, 5'd6, 32'hDEADBEEF);
    check_all("rt_wr_pre");
    tick();
    drive(0, 0, 0, 0, 5'd6, 5'd5, 5'd6, 32'h0);
    chk("rt_wr/r5", r5, 32'hDEADBEEF);
    chk("rt_wr/r6", r6, 32'h0);
    check_all("rt_wr");

    // 4. Writes to reg0 are ignored
    drive(0, 0, 1, 1, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFF);
    chk("reg0/busA_pre", busA, 32'h0);
    tick();
    chk("reg0/busA_post", busA, 32'h0);
    check_all("reg0");

    // 5. Preset beats write, then reset beats preset
    drive(0, 1, 1, 1, 5'd2, 5'd3, 5'd2, 32'h55);
    check_all("preset_pre");
    tick();
    drive(0, 0, 0, 0, 5'd31, 5'd2, 5'd0, 32'h0);
    chk("preset/r2", r2, 32'd2);
    chk("preset/r3", r3, 32'd3);
    chk("preset/r7", r7, 32'd7);
    chk("preset/busA31", busA, 32'd31);
    drive(1, 1, 1, 1, 5'd9, 5'd10, 5'd9, 32'h77);
    check_all("rst_ld_pre");
    tick();
    for (int i = 0; i < 32; i++) begin
      drive(0, 0, 0, 0, 5'(i), 5'(31 - i), 0, 32'h0);
      chk("rst_ld/busA", busA, 32'h0);
    end
    check_all("rst_ld");

    // 6. Dual read, then write-disabled edges
    drive(0, 0, 1, 1, 0, 0, 5'd4, 32'h1234);
    tick();
    drive(0, 0, 1, 0, 0, 5'd7, 5'd1, 32'hABCD);
    tick();
    drive(0, 0, 0, 0, 5'd4, 5'd7, 0, 32'h0);
    chk("dual/busA", busA, 32'h1234);
    chk("dual/busB", busB, 32'hABCD);
    for (int k = 0; k < 2; k++) begin
      drive(0, 0, 0, 1'($urandom), 5'd4, 5'd7, 5'($urandom), $urandom);
      tick();
      chk("dual_hold/busA", busA, 32'h1234);
      chk("dual_hold/busB", busB, 32'hABCD);
    end

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 24) == 0), ($urandom_range(0, 24) == 0),
            1'($urandom_range(0, 3) != 0), 1'($urandom),
            5'($urandom), 5'($urandom), 5'($urandom), $urandom);
      // Bias reads toward the write target to exercise bypass often.
      if ($urandom_range(0, 2) == 0) Rs = RegDst ? Rd : Rt;
      #1;
      check_all("rand");
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
